hex_scan_display: RTL

- Downstream display stage for the 8-bit LFSR state register: takes a packed hex value over a valid/ready handshake and drives a time-multiplexed common-segment 7-segment display.
- Decodes the full 0-F range.
- Scans one digit per refresh slot.
- Defers each new value to a frame boundary so a frame never mixes old and new digits.

---
 rtl/hex_scan_display_pkg.sv | 22 ++
 rtl/hex_scan_display_decode.sv | 15 +
 rtl/hex_scan_display.sv | 115 +++++++++++
 3 files changed

// File: rtl/hex_scan_display_pkg.sv
// Shared 7-segment constants for the hex scan display and the LFSR display path.
// Segment bytes are packed a..g,dp in bits 7..0, active-high.
package hex_scan_display_pkg;

  localparam logic [7:0] SEG_OFF = 8'h00;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Entry n is the glyph for hex digit n; the dp bit is always 0 here.
  localparam logic [0:15][7:0] SEG_TABLE = {
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

endpackage

// File: rtl/hex_scan_display_decode.sv
// Combinational hex nibble to 7-segment decoder with decimal point.
module hex7seg_decode
  import hex_scan_display_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg         = SEG_TABLE[i_nib];
    o_seg[SEG_DP] = i_dp;
  end

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display: one digit per SCAN_DIV clocks, new values
// are held pending and only swapped in at a frame boundary.
module hex_scan_display
  import hex_scan_display_pkg::*;
#(
  parameter  int NDIG     = 2,
  parameter  int SCAN_DIV = 50000,
  parameter  bit BLANK_LZ = 1'b0,
  localparam int DATA_W   = 4*NDIG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [NDIG-1:0]   in_dp,
  input  logic              blank,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_shown, r_pend;
  logic [NDIG-1:0]   r_shown_dp, r_pend_dp;
  logic              r_pend_v;
  logic [7:0]        r_seg;
  logic [NDIG-1:0]   r_an;
  logic              r_frame_done;

  logic                  w_tick, w_frame_end, w_accept;
  logic [NDIG-1:0][7:0]  w_lane_seg;
  logic [NDIG-1:0]       w_an_nxt;

  assign w_tick      = (r_cnt == CNT_W'(SCAN_DIV-1));
  assign w_frame_end = w_tick && (r_idx == IDX_W'(NDIG-1));
  assign in_ready    = !r_pend_v || w_frame_end;
  assign w_accept    = in_valid && in_ready;

  // Every digit is decoded in parallel; the scan index just picks a lane.
  for (genvar g = 0; g < NDIG; g++) begin : g_lane
    logic       w_lz;
    logic [7:0] w_dec;
    if (g == 0 || !BLANK_LZ) begin : g_nolz
      assign w_lz = 1'b0;
    end else begin : g_lz
      assign w_lz = (r_shown[DATA_W-1:4*g] == '0);
    end
    hex7seg_decode u_dec (
      .i_nib (r_shown[4*g +: 4]),
      .i_dp  (r_shown_dp[g]),
      .o_seg (w_dec)
    );
    assign w_lane_seg[g] = w_lz ? SEG_OFF : w_dec;
  end

  always_comb begin
    w_an_nxt        = '0;
    w_an_nxt[r_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= (r_idx == IDX_W'(NDIG-1)) ? '0 : r_idx + 1'b1;
    end
  end

  // A frame-end swap and a same-cycle accept can coexist: pending reloads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shown    <= '0;
      r_shown_dp <= '0;
      r_pend     <= '0;
      r_pend_dp  <= '0;
      r_pend_v   <= 1'b0;
    end else begin
      if (w_frame_end && r_pend_v) begin
        r_shown    <= r_pend;
        r_shown_dp <= r_pend_dp;
      end
      if (w_accept) begin
        r_pend    <= in_data;
        r_pend_dp <= in_dp;
        r_pend_v  <= 1'b1;
      end else if (w_frame_end) begin
        r_pend_v  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg        <= SEG_OFF;
      r_an         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= blank ? SEG_OFF : w_lane_seg[r_idx];
      r_an         <= blank ? '0 : w_an_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule
